// File: rtl/io_debounce.sv
// io_debounce: synchronises a slow asynchronous pin into clk and filters
// bounce/glitches with a counter-qualified four-state FSM. Produces a clean
// level (dout), a qualification-in-progress flag (busy) and a saturating
// count of rejected excursions (glitch_cnt).
module io_debounce #(
    parameter int   SYNC_FF         = 2,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter int   CNT_W           = 16,
    parameter logic RESET_LEVEL     = 1'b1,
    parameter int   GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
    input  logic                clr_glitch,
    output logic                dout,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    logic [SYNC_FF-1:0] sync_ff;
    logic               sync_q;
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               glitch;

    assign sync_q = sync_ff[SYNC_FF-1];

    // A rejection is a reversion of the synchronised pin while qualifying.
    assign glitch = ((state == WAIT_HI) && !sync_q) ||
                    ((state == WAIT_LO) &&  sync_q);

    // Synchroniser chain; preset to the reset level so no false candidate
    // appears right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_ff <= {SYNC_FF{RESET_LEVEL}};
        else     sync_ff <= {sync_ff[SYNC_FF-2:0], din};
    end

    // Debounce FSM: dout/busy are registered and updated with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
            dout  <= RESET_LEVEL;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                STABLE_LO: begin
                    if (sync_q) begin
                        state <= WAIT_HI;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync_q) begin
                        state <= STABLE_LO;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_HI;
                        busy  <= 1'b0;
                        dout  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync_q) begin
                        state <= WAIT_LO;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (sync_q) begin
                        state <= STABLE_HI;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        busy  <= 1'b0;
                        dout  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating glitch counter; a clear in the same cycle as a glitch wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     glitch_cnt <= '0;
        else if (clr_glitch)                         glitch_cnt <= '0;
        else if (glitch && (glitch_cnt != GLITCH_MAX)) glitch_cnt <= glitch_cnt + 1'b1;
    end

endmodule

// File: tb/tb_io_debounce.sv
// tb_io_debounce: directed bench for io_debounce (SYNC_FF=2, DEBOUNCE_CYCLES=4).
// A second instance with GLITCH_W=2 shares the stimulus for the saturation case.
module tb_io_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       clr_glitch;
    logic       dout, busy;
    logic [7:0] glitch_cnt;
    logic       dout_s, busy_s;
    logic [1:0] glitch_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

    io_debounce #(.SYNC_FF(2), .DEBOUNCE_CYCLES(4), .CNT_W(16),
                  .RESET_LEVEL(1'b1), .GLITCH_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .clr_glitch(clr_glitch),
        .dout(dout), .busy(busy), .glitch_cnt(glitch_cnt));

    io_debounce #(.SYNC_FF(2), .DEBOUNCE_CYCLES(4), .CNT_W(16),
                  .RESET_LEVEL(1'b1), .GLITCH_W(2)) dut_sat (
        .clk(clk), .rst(rst), .din(din), .clr_glitch(clr_glitch),
        .dout(dout_s), .busy(busy_s), .glitch_cnt(glitch_cnt_s));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Low pulse of len cycles from a high baseline; counts busy samples and dout falls.
    task automatic run_pulse(input int len, input int win, output int nbusy, output int nfall);
        logic prev;
        nbusy = 0;
        nfall = 0;
        prev  = dout;
        din   = 1'b0;
        for (int i = 1; i <= win; i++) begin
            tick();
            if (i == len) din = 1'b1;
            nbusy += int'(busy);
            if (prev && !dout) nfall++;
            prev = dout;
        end
    endtask

    initial begin
        int   nb, nf, t, last_rise, fall_t, falls;
        logic pb, pd;
        logic pat [9];
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; din = 1'b1; clr_glitch = 1'b0;
        tick(); tick();
        chk("rst_dout", dout, 1);
        chk("rst_busy", busy, 0);
        chk("rst_glitch", glitch_cnt, 0);
        rst = 1'b0;
        repeat (3) tick();

        // Clean 1->0: captured at edge j, busy after j+2, dout falls after j+6
        din = 1'b0;
        tick(); tick();
        chk("clean_busy_pre", busy, 0);
        tick();
        chk("clean_busy_on", busy, 1);
        chk("clean_dout_wait", dout, 1);
        repeat (3) tick();
        chk("clean_dout_hold", dout, 1);
        tick();
        chk("clean_dout_fall", dout, 0);
        chk("clean_busy_off", busy, 0);
        chk("clean_glitch", glitch_cnt, 0);
        din = 1'b1;
        repeat (8) tick();
        chk("clean_dout_rise", dout, 1);

        // Glitch rejection: 3 and 4 cycles rejected, 5 accepted
        run_pulse(3, 15, nb, nf);
        chk("g3_busy", nb, 3);
        chk("g3_falls", nf, 0);
        chk("g3_glitch", glitch_cnt, 1);
        run_pulse(4, 16, nb, nf);
        chk("g4_busy", nb, 4);
        chk("g4_falls", nf, 0);
        chk("g4_glitch", glitch_cnt, 2);
        run_pulse(5, 17, nb, nf);
        chk("g5_busy", nb, 8);
        chk("g5_falls", nf, 1);
        chk("g5_glitch", glitch_cnt, 2);
        chk("g5_dout_end", dout, 1);

        clr_glitch = 1'b1;
        tick();
        clr_glitch = 1'b0;
        chk("clr_glitch", glitch_cnt, 0);

        // Bounce train: lows 2,1,3 split by 1-cycle highs, then held low
        t = 0; last_rise = -1; fall_t = -1; falls = 0;
        pb = busy; pd = dout;
        for (int i = 0; i < 23; i++) begin
            din = (i < 9) ? pat[i] : 1'b0;
            tick();
            t++;
            if (busy && !pb) last_rise = t;
            if (pd && !dout) begin falls++; fall_t = t; end
            pb = busy; pd = dout;
        end
        chk("bounce_glitch", glitch_cnt, 3);
        chk("bounce_falls", falls, 1);
        chk("bounce_fall_lat", fall_t - last_rise, 4);
        chk("bounce_dout", dout, 0);

        // Reset with pin settled low: dout forced high, then re-qualified
        rst = 1'b1;
        #2;
        chk("rstA_dout", dout, 1);
        chk("rstA_busy", busy, 0);
        chk("rstA_glitch", glitch_cnt, 0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("rstA_dout_hold", dout, 1);
        tick();
        chk("rstA_dout_fall", dout, 0);
        din = 1'b1;
        repeat (8) tick();
        chk("rstA_dout_rise", dout, 1);

        // Reset mid-WAIT with cnt=2
        din = 1'b0;
        repeat (5) tick();
        chk("rstB_busy_pre", busy, 1);
        rst = 1'b1;
        #2;
        chk("rstB_busy", busy, 0);
        chk("rstB_dout", dout, 1);
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("rstB_busy_idle", busy, 0);
        tick();
        chk("rstB_busy_wait", busy, 1);
        repeat (3) tick();
        chk("rstB_dout_hold", dout, 1);
        tick();
        chk("rstB_dout_fall", dout, 0);
        din = 1'b1;
        repeat (8) tick();

        // Saturation: 5 glitches -> wide counter 5, 2-bit counter 3
        clr_glitch = 1'b1;
        tick();
        clr_glitch = 1'b0;
        chk("sat_clr", glitch_cnt_s, 0);
        for (int k = 0; k < 5; k++) run_pulse(2, 8, nb, nf);
        chk("sat_wide", glitch_cnt, 5);
        chk("sat_narrow", glitch_cnt_s, 3);
        chk("sat_dout", dout_s, 1);

        // Clear coinciding with a rejection edge: clear wins
        din = 1'b0;
        tick(); tick();
        din = 1'b1;
        tick(); tick();
        chk("coll_busy_pre", busy_s, 1);
        clr_glitch = 1'b1;
        tick();
        clr_glitch = 1'b0;
        chk("coll_busy_post", busy, 0);
        chk("coll_wide", glitch_cnt, 0);
        chk("coll_narrow", glitch_cnt_s, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_debounce.md
# io_debounce

Input conditioning stage for slow asynchronous I/O lines such as buttons, switches and strap pins. It synchronises a raw pin into `clk` and rejects bounce and glitches with a counter-based state machine. It then drives a clean, stable level into the downstream edge detector, which turns that level into single-cycle rise and fall pulses. It also reports its filtering status and keeps a saturating count of rejected glitches for diagnostics.

## Interface
Parameters:
- `SYNC_FF`, default 2: synchroniser depth; legal values are 2 or more.
- `DEBOUNCE_CYCLES`, default 1000: number of consecutive stable synchronised cycles required to accept a new level; legal range is 1 to 2^`CNT_W`-1.
- `CNT_W`, default 16: width of the debounce counter.
- `RESET_LEVEL`, default 1'b1: value loaded into the synchroniser and `dout` at reset.
- `GLITCH_W`, default 8: width of the glitch counter.

Ports:
- `clk`  input  1: the single clock.
- `rst`  input  1: asynchronous, active-high reset.
- `din`  input  1: raw asynchronous pin.
- `clr_glitch`  input  1: synchronous clear of `glitch_cnt`.
- `dout`  output  1: debounced level; feeds the edge detector's `din`.
- `busy`  output  1: high while a candidate transition is being qualified.
- `glitch_cnt`  output  `GLITCH_W`: saturating count of rejected transitions.

## Operation
- The synchroniser is a `SYNC_FF`-stage shift register clocked by `clk`. Its last stage, `sync_q`, is the only signal the FSM reads.
- The FSM has four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. The reset state is STABLE_HI if `RESET_LEVEL`=1, otherwise STABLE_LO.
- In STABLE_LO:
  - `sync_q`=1: go to WAIT_HI and set `cnt`=0.
  - Otherwise: stay.
- In WAIT_HI:
  - `sync_q`=0: return to STABLE_LO, set `cnt`=0, and increment `glitch_cnt`.
  - `sync_q`=1 and `cnt`==`DEBOUNCE_CYCLES`-1: go to STABLE_HI and set `dout`=1.
  - Otherwise: increment `cnt`.
- STABLE_HI and WAIT_LO are the mirror images of the above.
- `dout` is a register and changes only on a WAIT to STABLE transition.
- `busy` is a register and is 1 exactly while the state is WAIT_HI or WAIT_LO.
- `glitch_cnt` saturates at 2^`GLITCH_W`-1 and never wraps.
- `clr_glitch`=1 sets `glitch_cnt` to 0 on the next edge. If a glitch occurs in the same cycle, the clear wins and the result is 0, not 1.
- `cnt` never exceeds `DEBOUNCE_CYCLES`-1, so no overflow is possible within the legal parameter range.

## Timing
- Reset (asynchronous, takes effect immediately):
  - all synchroniser stages = `RESET_LEVEL`
  - `dout` = `RESET_LEVEL`
  - `busy` = 0
  - `glitch_cnt` = 0
  - `cnt` = 0
  - state = STABLE_x, matching `RESET_LEVEL`
- When `rst` deasserts, the first active edge performs normal operation.
- Let `din` take a new value that is first captured by the first synchroniser flop at edge j, and hold it:
  - `sync_q` shows the new value after edge j+`SYNC_FF`-1.
  - The FSM enters WAIT and `busy`=1 after edge j+`SYNC_FF`.
  - `dout` flips and `busy`=0 after edge j+`SYNC_FF`+`DEBOUNCE_CYCLES`.
- Rejection rule: a synchronised excursion lasting `DEBOUNCE_CYCLES` cycles or fewer is rejected. `dout` is unchanged, `busy` returns to 0 one edge after `sync_q` reverts, and `glitch_cnt` increments on that same edge.
- Bounce: every reversion during WAIT restarts qualification from `cnt`=0 on the next excursion.
- Reset asserted mid-WAIT abandons the candidate. `dout` returns to `RESET_LEVEL` even if the pin has settled at the other level; the FSM then re-qualifies that level normally after `rst` deasserts.
- With `RESET_LEVEL`=1 the output powers up high, matching the downstream detector's reset so no spurious edge is reported.

## Test plan
- **Reset:** `RESET_LEVEL`=1; hold `din`=0 and pulse `rst` mid-run. Required: `dout`=1, `busy`=0 and `glitch_cnt`=0 during reset; after release `dout` falls exactly `SYNC_FF`+`DEBOUNCE_CYCLES` edges after `din` is first captured.
- **Clean transition:** `SYNC_FF`=2, `DEBOUNCE_CYCLES`=4; `din` goes 1 to 0, first captured at edge 10. Required: `busy`=1 after edge 12; `dout`=0 and `busy`=0 after edge 16; `glitch_cnt` stays 0.
- **Glitch rejection:** same parameters; `din` low for 3 cycles then high again. Required: `dout` stays 1, `busy` pulses for 3 cycles, `glitch_cnt`=1. A second test with a 4-cycle pulse is also rejected; a 5-cycle pulse is accepted.
- **Bounce train:** lows of 2, 1 and 3 cycles separated by 1-cycle highs, then a held low. Required: `glitch_cnt`=3 and a single `dout` fall, 4 edges after the final WAIT entry.
- **Saturation and clear:** `GLITCH_W`=2; inject 5 glitches. Required: `glitch_cnt`=3. Then assert `clr_glitch` in the same cycle as a glitch; required: `glitch_cnt`=0.
- **Reset mid-WAIT:** assert `rst` when `cnt`=2. Required: `busy`=0 and `dout`=`RESET_LEVEL` immediately; after release a full `DEBOUNCE_CYCLES` qualification is required before `dout` changes.
